// File: rtl/fb_write_arbiter.sv
// Two-requester round-robin arbiter for the framebuffer pixel-write port, with burst
// locking, off-screen clipping and a registered valid/ready output stage.
module fb_write_arbiter #(
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CLIP_W    = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [9:0]        req0_x,
    input  logic [8:0]        req0_y,
    input  logic [1:0]        req0_pixel,
    input  logic              req0_last,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [9:0]        req1_x,
    input  logic [8:0]        req1_y,
    input  logic [1:0]        req1_pixel,
    input  logic              req1_last,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [9:0]        fb_x,
    output logic [8:0]        fb_y,
    output logic [1:0]        fb_pixel,
    output logic [1:0]        grant,
    output logic [CLIP_W-1:0] clip_count
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;  // 1: req1 wins the next contested IDLE
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fb_valid_q, fb_valid_d;
    logic [9:0]         fb_x_q, fb_x_d;
    logic [8:0]         fb_y_q, fb_y_d;
    logic [1:0]         fb_pixel_q, fb_pixel_d;
    logic [CLIP_W-1:0]  clip_q, clip_d;

    logic               slot_free;
    logic               acc;
    logic               clipped;
    logic               burst_end;
    logic [CNT_W-1:0]   cnt_inc;
    logic [9:0]         sel_x;
    logic [8:0]         sel_y;
    logic [1:0]         sel_pixel;
    logic               sel_last;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            fb_valid_q <= 1'b0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_pixel_q <= '0;
            clip_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            fb_valid_q <= fb_valid_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_pixel_q <= fb_pixel_d;
            clip_q     <= clip_d;
        end
    end

    // Output decode
    always_comb begin
        slot_free  = !fb_valid_q || fb_ready;
        req0_ready = (state_q == StG0) && slot_free;
        req1_ready = (state_q == StG1) && slot_free;
        grant      = {state_q == StG1, state_q == StG0};
        fb_valid   = fb_valid_q;
        fb_x       = fb_x_q;
        fb_y       = fb_y_q;
        fb_pixel   = fb_pixel_q;
        clip_count = clip_q;
    end

    // Current owner's beat
    always_comb begin
        sel_x     = req0_x;
        sel_y     = req0_y;
        sel_pixel = req0_pixel;
        sel_last  = req0_last;
        if (state_q == StG1) begin
            sel_x     = req1_x;
            sel_y     = req1_y;
            sel_pixel = req1_pixel;
            sel_last  = req1_last;
        end
        acc       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        clipped   = (32'(sel_x) >= H_RES) || (32'(sel_y) >= V_RES);
        cnt_inc   = cnt_q + CNT_W'(1);
        burst_end = acc && (sel_last || (cnt_inc == CNT_W'(MAX_BURST)));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid && req1_valid) state_d = ptr_q ? StG1 : StG0;
                else if (req0_valid)          state_d = StG0;
                else if (req1_valid)          state_d = StG1;
            end
            StG0: begin
                if (burst_end) begin
                    ptr_d   = 1'b1;
                    state_d = req1_valid ? StG1 : StIdle;
                end
            end
            StG1: begin
                if (burst_end) begin
                    ptr_d   = 1'b0;
                    state_d = req0_valid ? StG0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (burst_end)  cnt_d = '0;
        else if (acc)   cnt_d = cnt_inc;
    end

    // Output register and clip counter
    always_comb begin
        fb_valid_d = fb_valid_q;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_pixel_d = fb_pixel_q;
        clip_d     = clip_q;
        // Acceptance implies the slot is free, so loading never overwrites an undrained beat
        if (acc && !clipped) begin
            fb_valid_d = 1'b1;
            fb_x_d     = sel_x;
            fb_y_d     = sel_y;
            fb_pixel_d = sel_pixel;
        end else if (fb_ready) begin
            fb_valid_d = 1'b0;
        end
        if (acc && clipped && (clip_q != '1)) clip_d = clip_q + CLIP_W'(1);
    end

endmodule
